// File: rtl/uart_receiver_if.sv
// Core-side handshake of the UART receiver: received byte, strobes and status.
// The receiver drives the outputs through master; the consuming core uses slave.
interface uart_receiver_if;
    logic       rd_ack;
    logic [7:0] data;
    logic       valid;
    logic       pending;
    logic       overrun;
    logic       framing_err;
    logic       busy;

    modport master (
        input  rd_ack,
        output data, valid, pending, overrun, framing_err, busy
    );

    modport slave (
        output rd_ack,
        input  data, valid, pending, overrun, framing_err, busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, idle-high line, with a two-flop input synchronizer,
// a pending/ack handshake to the core, and one-cycle valid/overrun/framing flags.
//
//  state | meaning
//  IDLE  | line idle, waiting for rx_s low
//  START | half a bit into the start bit, confirm it is still low
//  DATA  | sample 8 data bits at their centres
//  STOP  | sample stop bit at its centre, deliver byte or flag framing error
//  BREAK | line stuck low after a bad stop bit, wait for it to go high
module uart_receiver #(
    parameter int CLKS_PER_BIT = 261
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RxD,
    uart_receiver_if.master  rx_if
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          pending_q;
    logic          overrun_q;
    logic          framing_q;
    // Tracks an unconsumed byte; differs from pending only when rd_ack coincided with valid.
    logic          unacked;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sync      <= 2'b11;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
            unacked   <= 1'b0;
        end else begin
            sync      <= {sync[0], RxD};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
            if (rx_if.rd_ack && pending_q) begin
                pending_q <= 1'b0;
                unacked   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (bit_cnt == HALF_M1) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_M1) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_M1) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            data_q    <= shreg;
                            valid_q   <= 1'b1;
                            pending_q <= 1'b1;
                            overrun_q <= unacked;
                            // An ack landing with the new byte counts as consuming it.
                            unacked   <= ~rx_if.rd_ack;
                            state     <= IDLE;
                        end else begin
                            framing_q <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    bit_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_if.data        = data_q;
    assign rx_if.valid       = valid_q;
    assign rx_if.pending     = pending_q;
    assign rx_if.overrun     = overrun_q;
    assign rx_if.framing_err = framing_q;
    assign rx_if.busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clk per bit: stimulus pushes expected bytes,
// a negedge monitor pops and compares data, overrun flag and arrival cycle.
module tb_uart_receiver;
    localparam int CPB = 16;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic clk;
    logic reset;
    logic RxD;
    int   cyc;
    int   checks;
    int   errors;
    int   v_cnt;
    int   fe_cnt;
    logic v_prev;

    typedef struct {
        logic [7:0] d;
        logic       ovr;
        int         at;
    } exp_t;
    exp_t sb[$];

    uart_receiver_if rx_if ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .RxD   (RxD),
        .rx_if (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: valid strobes are matched against the scoreboard in order.
    always @(negedge clk) begin
        if (reset) begin
            if (v_prev) chk("valid_one_cycle", rx_if.valid, 0);
            v_prev = rx_if.valid;
            if (rx_if.framing_err) fe_cnt++;
            if (rx_if.overrun) chk("overrun_with_valid", rx_if.valid, 1);
            if (rx_if.valid) begin
                v_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 0, 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", rx_if.data, e.d);
                    chk("overrun", rx_if.overrun, e.ovr);
                    chk("valid_cycle", cyc, e.at);
                end
            end
        end else begin
            v_prev = 1'b0;
        end
    end

    // Each bit held for CPB cycles, index 0 first. Called right after a negedge, so the
    // next posedge is the start edge and valid is seen at the negedge after edge LAT.
    task automatic tx_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            RxD = frame[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_exp(input logic [7:0] b, input logic ovr);
        exp_t e;
        e.d = b;
        e.ovr = ovr;
        e.at = cyc + LAT;
        sb.push_back(e);
        tx_bits({1'b1, b, 1'b0}, 10);
    endtask

    task automatic ack();
        rx_if.rd_ack = 1'b1;
        @(negedge clk);
        rx_if.rd_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; v_cnt = 0; fe_cnt = 0; v_prev = 1'b0;
        reset = 1'b0;
        RxD = 1'b1;
        rx_if.rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", rx_if.data, 0);
        chk("rst_valid", rx_if.valid, 0);
        chk("rst_pending", rx_if.pending, 0);
        chk("rst_busy", rx_if.busy, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: plain byte
        send_exp(8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        chk("t1_data", rx_if.data, 8'hA5);
        chk("t1_pending", rx_if.pending, 1);
        chk("t1_fe", fe_cnt, 0);
        ack();
        chk("t1_ack_pending", rx_if.pending, 0);

        // 2: 4-cycle glitch on the line
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_busy_in_start", rx_if.busy, 1);
        RxD = 1'b1;
        repeat (8) @(negedge clk);
        chk("t2_busy_dropped", rx_if.busy, 0);
        repeat (20) @(negedge clk);
        chk("t2_fe", fe_cnt, 0);
        chk("t2_valids", v_cnt, 1);

        // 3: bad stop bit then a long break, then a good frame
        tx_bits({1'b0, 8'h3C, 1'b0}, 10);
        RxD = 1'b0;
        repeat (40) @(negedge clk);
        RxD = 1'b1;
        repeat (20) @(negedge clk);
        chk("t3_fe_once", fe_cnt, 1);
        chk("t3_data_kept", rx_if.data, 8'hA5);
        chk("t3_pending_kept", rx_if.pending, 0);
        chk("t3_busy", rx_if.busy, 0);
        // 0x5A with rd_ack held across the edge that raises valid
        begin
            exp_t e;
            e.d = 8'h5A; e.ovr = 1'b0; e.at = cyc + LAT;
            sb.push_back(e);
        end
        tx_bits({1'b1, 8'h5A, 1'b0}, 9);
        RxD = 1'b1;
        repeat (LAT - 9 * CPB - 1) @(negedge clk);
        rx_if.rd_ack = 1'b1;
        @(negedge clk);
        rx_if.rd_ack = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_set_wins", rx_if.pending, 1);
        chk("t3_data", rx_if.data, 8'h5A);

        // 4: the ack above consumed 0x5A, so only 0x22 overruns
        send_exp(8'h11, 1'b0);
        send_exp(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        chk("t4_data", rx_if.data, 8'h22);
        chk("t4_pending", rx_if.pending, 1);
        ack();
        chk("t4_ack_pending", rx_if.pending, 0);

        // 5: reset in the middle of data bit 4 of 0xF0
        tx_bits({1'b1, 8'hF0, 1'b0}, 5);
        RxD = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        chk("t5_busy_before", rx_if.busy, 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_data", rx_if.data, 0);
        chk("t5_rst_busy", rx_if.busy, 0);
        chk("t5_rst_pending", rx_if.pending, 0);
        chk("t5_rst_flags", {rx_if.valid, rx_if.overrun, rx_if.framing_err}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send_exp(8'h81, 1'b0);
        repeat (4) @(negedge clk);
        chk("t5_data", rx_if.data, 8'h81);
        chk("t5_pending", rx_if.pending, 1);
        ack();

        // 6: back-to-back frames, second one overruns the unacked first
        send_exp(8'h00, 1'b0);
        send_exp(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6_data", rx_if.data, 8'hFF);

        chk("sb_drained", sb.size(), 0);
        chk("total_valids", v_cnt, 7);
        chk("total_fe", fe_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
